unshifter32: RTL and testbench

UNSHIFTER32 -- requirements
Module: unshifter32

---
 rtl/unshifter32_pkg.sv | 60 ++++++
 rtl/unshifter32.sv | 106 ++++++++++
 tb/tb_unshifter32.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unshifter32_pkg.sv
// -----------------------------------------------------------------------------
// unshifter32_pkg
// Shared widths, FSM state encoding and datapath helpers for the unshifter32
// decoder. The decoder rebuilds a 32-bit value from its leading-one position
// (k) and the 8 bits directly below that leading one (m1).
// -----------------------------------------------------------------------------
package unshifter32_pkg;

  localparam int NUM_LENGTH = 32;
  localparam int K_LENGTH   = 5;
  localparam int M1_LENGTH  = 8;
  localparam int CNT_LENGTH = 3;

  // Stage counter walks 4,3,2,1,0 and then wraps to 7, which marks the
  // extra cycle that copies the finished accumulator into the output register.
  localparam logic [CNT_LENGTH-1:0] CNT_FIRST = 3'd4;
  localparam logic [CNT_LENGTH-1:0] CNT_DRAIN = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Places the implicit leading one at bit 31 with m1 right below it; the
  // shift stages then move it down to bit position k.
  function automatic logic [NUM_LENGTH-1:0] load_value(
    input logic [M1_LENGTH-1:0] m1,
    input logic                 zero
  );
    logic [NUM_LENGTH-1:0] r;
    if (zero) begin
      r = {NUM_LENGTH{1'b0}};
    end else begin
      r = {1'b1, m1, {(NUM_LENGTH-1-M1_LENGTH){1'b0}}};
    end
    return r;
  endfunction

  // One binary shift stage: a cleared k bit means the leading one must move
  // down by 2^stage, so the total right shift over all stages is 31 - k.
  function automatic logic [NUM_LENGTH-1:0] stage_shift(
    input logic [NUM_LENGTH-1:0] acc,
    input logic [CNT_LENGTH-1:0] stage,
    input logic [K_LENGTH-1:0]   k
  );
    logic [NUM_LENGTH-1:0] r;
    r = acc;
    case (stage)
      3'd0:    r = k[0] ? acc : (acc >> 5'd1);
      3'd1:    r = k[1] ? acc : (acc >> 5'd2);
      3'd2:    r = k[2] ? acc : (acc >> 5'd4);
      3'd3:    r = k[3] ? acc : (acc >> 5'd8);
      3'd4:    r = k[4] ? acc : (acc >> 5'd16);
      default: r = acc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unshifter32.sv
// -----------------------------------------------------------------------------
// unshifter32
// Decodes (k, m1, zero) back into a 32-bit value using a multi-cycle barrel
// shifter: one 2^i shift stage per cycle, followed by one cycle that registers
// the result. Fixed latency of 6 cycles from accept to out_valid.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   encoded value present on in_k/in_m1/in_zero
//   in_ready   block idle and able to accept (state == IDLE)
//   in_k       leading-one position of the original value
//   in_m1      8 bits below the leading one, MSB-aligned
//   in_zero    encoded value is zero; in_k/in_m1 ignored
//   out_valid  num holds a decoded result (state == DONE)
//   out_ready  consumer takes num this cycle
//   num        decoded value, held stable while out_ready = 0
// -----------------------------------------------------------------------------
module unshifter32
  import unshifter32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K_LENGTH-1:0]   in_k,
  input  logic [M1_LENGTH-1:0]  in_m1,
  input  logic                  in_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_LENGTH-1:0] num
);

  state_t                 state_q, state_d;
  logic [NUM_LENGTH-1:0]  acc_q,   acc_d;
  logic [K_LENGTH-1:0]    k_q,     k_d;
  logic [CNT_LENGTH-1:0]  cnt_q,   cnt_d;
  logic [NUM_LENGTH-1:0]  num_q,   num_d;

  // Next-state logic for FSM, accumulator, latched k, stage counter and result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = load_value(in_m1, in_zero);
          k_d     = in_k;
          cnt_d   = CNT_FIRST;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_DRAIN) begin
          // All five stages applied; publish the result and present it.
          num_d   = acc_q;
          cnt_d   = {CNT_LENGTH{1'b0}};
          state_d = ST_DONE;
        end else begin
          // Decrementing from stage 0 wraps to CNT_DRAIN.
          acc_d   = stage_shift(acc_q, cnt_q, k_q);
          cnt_d   = cnt_q - 3'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Returning to IDLE first keeps a new accept out of this cycle.
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state register bank with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= {NUM_LENGTH{1'b0}};
      k_q     <= {K_LENGTH{1'b0}};
      cnt_q   <= {CNT_LENGTH{1'b0}};
      num_q   <= {NUM_LENGTH{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign num       = num_q;

endmodule

// File: tb/tb_unshifter32.sv
// -----------------------------------------------------------------------------
// tb_unshifter32
// Directed vector table, hand-written back-pressure and reset sequences, and
// an encoder/decoder round trip against an independent encoder model.
// -----------------------------------------------------------------------------
module tb_unshifter32;

  typedef struct {
    logic [4:0]  k;
    logic [7:0]  m1;
    logic        zero;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_k;
  logic [7:0]  in_m1;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] num;

  int total = 0;
  int bad   = 0;

  vec_t vecs [15];

  unshifter32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_k      (in_k),
    .in_m1     (in_m1),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num       (num)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Present one input while idle; returns #1 after the accepting edge.
  task automatic accept(input logic [4:0] k, input logic [7:0] m1, input logic z, input bit hold);
    in_k     = k;
    in_m1    = m1;
    in_zero  = z;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Count edges after the accept until out_valid, then check latency and num.
  task automatic wait_out(input string name, input logic [31:0] exp);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 20) begin
      @(posedge clk);
      #1;
      c++;
      if (out_valid) seen = 1'b1;
    end
    check({name, "_latency"}, c, 32'd6);
    check({name, "_num"}, num, exp);
  endtask

  // Full transaction with out_ready high, finishing back in IDLE.
  task automatic run_vec(input string name, input logic [4:0] k, input logic [7:0] m1,
                         input logic z, input logic [31:0] exp);
    check({name, "_ready_pre"}, {31'd0, in_ready}, 32'd1);
    accept(k, m1, z, 1'b0);
    check({name, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_out(name, exp);
    @(posedge clk);
    #1;
    check({name, "_idle_post"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Independent encoder: leading-one position plus the next 8 bits.
  task automatic encode(input logic [31:0] v, output logic [4:0] k, output logic [7:0] m1,
                        output logic [31:0] masked);
    int p;
    logic [31:0] aligned;
    logic [31:0] mask;
    p = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) p = i;
    end
    k = p[4:0];
    aligned = v << (31 - p);
    m1 = aligned[30:23];
    if (p >= 8) mask = ~((32'd1 << (p - 8)) - 32'd1);
    else mask = 32'hFFFF_FFFF;
    masked = v & mask;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, want test end");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [4:0]  rk;
    logic [7:0]  rm;
    logic [31:0] rv;
    logic [31:0] rexp;
    logic [31:0] held;
    bit          rose;

    vecs[0]  = '{5'd10, 8'h80, 1'b0, 32'h0000_0600};
    vecs[1]  = '{5'd3,  8'hA0, 1'b0, 32'h0000_000D};
    vecs[2]  = '{5'd31, 8'hFF, 1'b0, 32'hFF80_0000};
    vecs[3]  = '{5'd0,  8'hFF, 1'b0, 32'h0000_0001};
    vecs[4]  = '{5'd17, 8'h55, 1'b1, 32'h0000_0000};
    vecs[5]  = '{5'd0,  8'h00, 1'b0, 32'h0000_0001};
    vecs[6]  = '{5'd8,  8'h00, 1'b0, 32'h0000_0100};
    vecs[7]  = '{5'd8,  8'h5A, 1'b0, 32'h0000_015A};
    vecs[8]  = '{5'd31, 8'h00, 1'b0, 32'h8000_0000};
    vecs[9]  = '{5'd16, 8'hC3, 1'b0, 32'h0001_C300};
    vecs[10] = '{5'd7,  8'hFF, 1'b0, 32'h0000_00FF};
    vecs[11] = '{5'd4,  8'h80, 1'b0, 32'h0000_0018};
    vecs[12] = '{5'd20, 8'h01, 1'b0, 32'h0010_1000};
    vecs[13] = '{5'd31, 8'hFF, 1'b1, 32'h0000_0000};
    vecs[14] = '{5'd1,  8'h80, 1'b0, 32'h0000_0003};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_k      = 5'd0;
    in_m1     = 8'd0;
    in_zero   = 1'b0;
    out_ready = 1'b1;

    // Reset state before any clock edge.
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_num", num, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].k, vecs[i].m1, vecs[i].zero, vecs[i].exp);
    end

    // Back-pressure: DONE held 10 cycles while a different input is offered.
    out_ready = 1'b0;
    accept(5'd10, 8'h80, 1'b0, 1'b0);
    wait_out("bp_first", 32'h0000_0600);
    held     = num;
    in_k     = 5'd5;
    in_m1    = 8'h11;
    in_zero  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_num%0d", i), num, held);
      check($sformatf("bp_hold_rdy%0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_hold_vld%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", {31'd0, in_ready}, 32'd1);
    check("bp_release_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_taken", {31'd0, in_ready}, 32'd0);
    wait_out("bp_second", 32'h0000_0022);
    @(posedge clk);
    #1;

    // Reset in the 3rd SHIFT cycle discards the value immediately.
    accept(5'd9, 8'h33, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_num", num, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) rose = 1'b1;
    end
    check("arst_no_output", {31'd0, rose}, 32'd0);
    check("arst_idle", {31'd0, in_ready}, 32'd1);

    // First accept on the first edge after reset release.
    rst      = 1'b1;
    #2;
    in_k     = 5'd31;
    in_m1    = 8'h00;
    in_zero  = 1'b0;
    in_valid = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_taken", {31'd0, in_ready}, 32'd0);
    wait_out("post_rst", 32'h8000_0000);
    @(posedge clk);
    #1;

    // Round trip through the encoder model.
    for (int i = 0; i < 1000; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      if (rv == 32'd0) rv = 32'd1;
      encode(rv, rk, rm, rexp);
      accept(rk, rm, 1'b0, 1'b0);
      wait_out($sformatf("rt%0d_%08h", i, rv), rexp);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
